// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory port between icache (m0) and dcache (m1), with a stall watchdog
module mem_bus_arbiter #(
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  input  logic        m0_re,
  input  logic        m0_we,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  input  logic        m1_re,
  input  logic        m1_we,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataOut,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_dataIn,
  input  logic        mem_ready,
  output logic        busError,
  input  logic        errClr
);
  typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;
  state_t state, nextState;
  logic lastGrant;
  logic [TIMEOUT_WIDTH-1:0] wdCnt;
  logic req0, req1, sel1, granted, active, stall, timeout;
  assign req0 = m0_re | m0_we;
  assign req1 = m1_re | m1_we;
  assign sel1 = state == S_GNT1;
  assign granted = !res && state != S_IDLE;
  assign active = granted && (sel1 ? req1 : req0);
  assign stall = active && !mem_ready;
  assign timeout = stall && wdCnt == TIMEOUT_WIDTH'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (res) begin
      state <= S_IDLE;
      lastGrant <= 1'b1;
      wdCnt <= '0;
      busError <= 1'b0;
    end else begin
      state <= nextState;
      lastGrant <= (state != S_IDLE && nextState == S_IDLE) ? sel1 : lastGrant;
      wdCnt <= (stall && !timeout) ? wdCnt + 1'b1 : '0;
      busError <= timeout | (busError & ~errClr);
    end
  end
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: nextState = (req0 && req1) ? (lastGrant ? S_GNT0 : S_GNT1) :
                          req0 ? S_GNT0 : req1 ? S_GNT1 : S_IDLE;
      S_GNT0: nextState = req0 ? S_GNT0 : S_IDLE;
      S_GNT1: nextState = req1 ? S_GNT1 : S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end
  always_comb begin
    mem_addr = granted ? (sel1 ? m1_addr : m0_addr) : '0;
    mem_dataOut = granted ? (sel1 ? m1_dataOut : m0_dataOut) : '0;
    mem_re = active && !timeout && (sel1 ? m1_re : m0_re);
    mem_we = active && !timeout && (sel1 ? m1_we : m0_we);
    m0_ready = active && !sel1 && (mem_ready || timeout);
    m1_ready = active && sel1 && (mem_ready || timeout);
    m0_dataIn = (timeout && !sel1) ? '0 : mem_dataIn;
    m1_dataIn = (timeout && sel1) ? '0 : mem_dataIn;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus scoreboarded multi-cycle sequences for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_1000;
  localparam logic [31:0] D0 = 32'hA0A0_0000, D1 = 32'hB1B1_0000, MD = 32'hD00D_F00D;
  typedef struct packed {
    logic [31:0] addr, dout;
    logic re, we, r0, r1, err, z0;
  } exp_t;
  typedef struct packed {
    logic [6:0] in;
    exp_t e;
  } vec_t;
  logic clk = 0, res = 1;
  logic m0_re = 0, m0_we = 0, m1_re = 0, m1_we = 0, mem_ready = 0, errClr = 0;
  logic [31:0] m0_addr = A0, m1_addr = A1, m0_dataOut = D0, m1_dataOut = D1, mem_dataIn = MD;
  logic [31:0] m0_dataIn, m1_dataIn, mem_addr, mem_dataOut;
  logic m0_ready, m1_ready, mem_re, mem_we, busError;
  exp_t sb[$];
  vec_t vecs[15];
  int nChk = 0, nFail = 0;
  always #5 clk = ~clk;
  mem_bus_arbiter dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_re(m0_re), .m0_we(m0_we),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_re(m1_re), .m1_we(m1_we),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_dataOut(mem_dataOut), .mem_re(mem_re), .mem_we(mem_we),
    .mem_dataIn(mem_dataIn), .mem_ready(mem_ready),
    .busError(busError), .errClr(errClr)
  );
  function automatic exp_t ex(int g, logic re, logic we, logic r0, logic r1, logic err, logic z0);
    exp_t e;
    e.addr = g == 1 ? A0 : g == 2 ? A1 : 32'h0;
    e.dout = g == 1 ? D0 : g == 2 ? D1 : 32'h0;
    e.re = re;
    e.we = we;
    e.r0 = r0;
    e.r1 = r1;
    e.err = err;
    e.z0 = z0;
    return e;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nChk++;
    if (a !== e) begin
      nFail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  task automatic cyc(logic [6:0] in, exp_t e);
    exp_t x;
    {res, m0_re, m0_we, m1_re, m1_we, mem_ready, errClr} = in;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk("mem_addr", mem_addr, x.addr);
    chk("mem_dataOut", mem_dataOut, x.dout);
    chk("mem_re", {31'h0, mem_re}, {31'h0, x.re});
    chk("mem_we", {31'h0, mem_we}, {31'h0, x.we});
    chk("m0_ready", {31'h0, m0_ready}, {31'h0, x.r0});
    chk("m1_ready", {31'h0, m1_ready}, {31'h0, x.r1});
    chk("busError", {31'h0, busError}, {31'h0, x.err});
    chk("m0_dataIn", m0_dataIn, x.z0 ? 32'h0 : MD);
    chk("m1_dataIn", m1_dataIn, MD);
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{7'b1000000, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{7'b1000000, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{7'b0001010, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{7'b0001010, ex(2, 1, 0, 0, 1, 0, 0)};
    vecs[4]  = '{7'b0001000, ex(2, 1, 0, 0, 0, 0, 0)};
    vecs[5]  = '{7'b0000000, ex(2, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{7'b0000000, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{7'b1000000, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{7'b0100110, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{7'b0100110, ex(1, 1, 0, 1, 0, 0, 0)};
    vecs[10] = '{7'b0000100, ex(1, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{7'b0000110, ex(0, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{7'b0000110, ex(2, 0, 1, 0, 1, 0, 0)};
    vecs[13] = '{7'b0000000, ex(2, 0, 0, 0, 0, 0, 0)};
    vecs[14] = '{7'b0000000, ex(0, 0, 0, 0, 0, 0, 0)};
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) cyc(vecs[i].in, vecs[i].e);
    cyc(7'b1000000, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0000110, ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 256; i++) cyc(7'b0100110, ex(2, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 256; i++) cyc(7'b0101010, ex(2, 1, 0, 0, 1, 0, 0));
    cyc(7'b0100000, ex(2, 0, 0, 0, 0, 0, 0));
    cyc(7'b0100010, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0100010, ex(1, 1, 0, 1, 0, 0, 0));
    cyc(7'b0000000, ex(1, 0, 0, 0, 0, 0, 0));
    cyc(7'b1000000, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0100000, ex(0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 255; i++) cyc(7'b0100000, ex(1, 1, 0, 0, 0, 0, 0));
    cyc(7'b0100000, ex(1, 0, 0, 1, 0, 0, 1));
    cyc(7'b0100001, ex(1, 1, 0, 0, 0, 1, 0));
    for (int i = 2; i < 255; i++) cyc(7'b0100000, ex(1, 1, 0, 0, 0, 0, 0));
    cyc(7'b0100001, ex(1, 0, 0, 1, 0, 0, 1));
    cyc(7'b0100000, ex(1, 1, 0, 0, 0, 1, 0));
    cyc(7'b1000000, ex(0, 0, 0, 0, 0, 1, 0));
    cyc(7'b0001010, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0001010, ex(2, 1, 0, 0, 1, 0, 0));
    cyc(7'b1001010, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0001010, ex(0, 0, 0, 0, 0, 0, 0));
    cyc(7'b0001010, ex(2, 1, 0, 0, 1, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
